sha1_block_engine: RTL

Parametrised SHA-1 engine that hashes a byte-length message of arbitrary size held in dual-port SRAM. It computes FIPS 180-4 padding internally, with no externally supplied pad length. It processes any number of 512-bit blocks and chains the H0..H4 state between them. It replaces the single-block top-level hash wrapper and uses the same start_hash/done and port_A memory interface.

---
 rtl/sha1_pkg.sv | 39 +++
 rtl/sha1_block_engine_pad_gen.sv | 38 +++
 rtl/sha1_block_engine.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - SHA-1 engine shared types, constants and round helpers
package sha1_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_UPDATE,
      S_WB,
      S_DONE
   } state_t;

   localparam int ROUNDS      = 80;
   localparam int BLOCK_WORDS = 16;

   localparam logic [159:0] H_INIT = {32'h6745_2301, 32'hEFCD_AB89, 32'h98BA_DCFE,
                                      32'h1032_5476, 32'hC3D2_E1F0};

   localparam logic [31:0] K_0 = 32'h5A82_7999;
   localparam logic [31:0] K_1 = 32'h6ED9_EBA1;
   localparam logic [31:0] K_2 = 32'h8F1B_BCDC;
   localparam logic [31:0] K_3 = 32'hCA62_C1D6;

   function automatic logic [31:0] sha1_k(input logic [6:0] t);
      if (t < 7'd20)      return K_0;
      else if (t < 7'd40) return K_1;
      else if (t < 7'd60) return K_2;
      else                return K_3;
   endfunction

   function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      if (t < 7'd20)      return (b & c) | (~b & d);
      else if (t < 7'd40) return b ^ c ^ d;
      else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
      else                return b ^ c ^ d;
   endfunction

endpackage

// File: rtl/sha1_block_engine_pad_gen.sv
// rtl/sha1_block_engine_pad_gen.sv - combinational message word composer (data, 0x80 marker, zero fill, bit length)
module sha1_pad_gen #(
   parameter int SIZE_W = 32
) (
   input  logic [SIZE_W+3:0] g,
   input  logic [SIZE_W-1:0] message_size,
   input  logic [31:0]       raw,
   input  logic              last_blk,
   output logic [31:0]       w
);
   import sha1_pkg::*;

   logic [SIZE_W+5:0] byte_off;
   logic [SIZE_W+5:0] size_ext;
   logic [63:0]       bit_len;

   always_comb begin
      byte_off = {g, 2'b00};
      size_ext = {6'b0, message_size};
      bit_len  = '0;
      bit_len[SIZE_W+2:0] = {message_size, 3'b000};
      w = '0;
      if (last_blk && g[3:1] == 3'b111) begin
         w = g[0] ? bit_len[31:0] : bit_len[63:32];
      end else if (byte_off + (SIZE_W+6)'(4) <= size_ext) begin
         w = raw;
      end else if (byte_off <= size_ext) begin
         // word holds the end of the message; size mod 4 is the count of kept bytes
         case (message_size[1:0])
            2'd0:    w = 32'h8000_0000;
            2'd1:    w = {raw[31:24], 24'h80_0000};
            2'd2:    w = {raw[31:16], 16'h8000};
            default: w = {raw[31:8], 8'h80};
         endcase
      end
   end

endmodule

// File: rtl/sha1_block_engine.sv
// rtl/sha1_block_engine.sv - multi-block SHA-1 over SRAM with internal padding; SHA1_DIGEST_WB_EN adds digest writeback
module sha1_block_engine #(
   parameter int ADDR_W = 16,
   parameter int SIZE_W = 32
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start_hash,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [SIZE_W-1:0] message_size,
   input  logic [ADDR_W-1:0] digest_addr,
   output logic [159:0]      hash,
   output logic              done,
   output logic              busy,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   input  logic [31:0]       port_A_data_out,
   output logic [31:0]       port_A_data_in,
   output logic              port_A_we
);
   import sha1_pkg::*;

   state_t            state, state_nx;
   logic [6:0]        cnt;
   logic [SIZE_W-1:0] size_q, blk;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       va, vb, vc, vd, ve;
   logic [31:0]       w_buf [16];
   logic [31:0]       pad_w, w_mix, w_t, temp;
   logic [159:0]      h_base;
   logic [SIZE_W:0]   last_idx;
   logic              last_blk, accept;
   logic [3:0]        ld_idx;
`ifdef SHA1_DIGEST_WB_EN
   logic [ADDR_W-1:0] dig_q;
`endif

   assign port_A_clk = clk;
   assign accept     = start_hash && (state == S_IDLE || state == S_DONE);
   assign last_idx   = ({1'b0, size_q} + (SIZE_W+1)'(8)) >> 6;
   assign last_blk   = ({1'b0, blk} == last_idx);
   // read data lags the address by one cycle, so load slot cnt carries word cnt-1
   assign ld_idx     = cnt[3:0] - 4'd1;
   assign h_base     = (blk == '0) ? H_INIT : hash;

   sha1_pad_gen #(.SIZE_W(SIZE_W)) u_pad (
      .g           ({blk, ld_idx}),
      .message_size(size_q),
      .raw         (port_A_data_out),
      .last_blk    (last_blk),
      .w           (pad_w)
   );

   always_comb begin
      w_mix = w_buf[cnt[3:0] + 4'd13] ^ w_buf[cnt[3:0] + 4'd8] ^
              w_buf[cnt[3:0] + 4'd2] ^ w_buf[cnt[3:0]];
      w_t   = (cnt < 7'd16) ? w_buf[cnt[3:0]] : {w_mix[30:0], w_mix[31]};
      temp  = {va[26:0], va[31:27]} + sha1_f(cnt, vb, vc, vd) + ve + sha1_k(cnt) + w_t;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (start_hash) state_nx = S_LOAD;
         S_LOAD:         if (cnt == 7'(BLOCK_WORDS)) state_nx = S_ROUND;
         S_ROUND:        if (cnt == 7'(ROUNDS - 1)) state_nx = S_UPDATE;
         S_UPDATE: begin
            if (!last_blk) state_nx = S_LOAD;
`ifdef SHA1_DIGEST_WB_EN
            else state_nx = S_WB;
`else
            else state_nx = S_DONE;
`endif
         end
         S_WB:           if (cnt == 7'd4) state_nx = S_DONE;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? 7'd0 : cnt + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_LOAD && cnt != 7'd0) w_buf[ld_idx] <= pad_w;
      else if (state == S_ROUND)          w_buf[cnt[3:0]] <= w_t;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         hash        <= '0;
         done        <= 1'b0;
         busy        <= 1'b0;
         blk         <= '0;
         size_q      <= '0;
         base_q      <= '0;
         port_A_addr <= '0;
         {va, vb, vc, vd, ve} <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_hash) begin
                  size_q      <= message_size;
                  base_q      <= message_addr;
                  blk         <= '0;
                  port_A_addr <= message_addr;
                  done        <= 1'b0;
                  busy        <= 1'b1;
               end else if (state == S_DONE) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            S_LOAD: begin
               if (cnt < 7'd15) port_A_addr <= base_q + ADDR_W'({blk, cnt[3:0] + 4'd1});
               if (cnt == 7'(BLOCK_WORDS)) {va, vb, vc, vd, ve} <= h_base;
            end
            S_ROUND: begin
               ve <= vd;
               vd <= vc;
               vc <= {vb[1:0], vb[31:2]};
               vb <= va;
               va <= temp;
            end
            S_UPDATE: begin
               hash <= {h_base[159:128] + va, h_base[127:96] + vb, h_base[95:64] + vc,
                        h_base[63:32] + vd, h_base[31:0] + ve};
               if (!last_blk) begin
                  blk         <= blk + 1'b1;
                  port_A_addr <= base_q + ADDR_W'({blk + 1'b1, 4'b0000});
               end
            end
`ifdef SHA1_DIGEST_WB_EN
            S_WB: port_A_addr <= dig_q + ADDR_W'(cnt);
`endif
            default: ;
         endcase
      end
   end

`ifdef SHA1_DIGEST_WB_EN
   always_ff @(posedge clk) begin
      if (!nreset) begin
         dig_q          <= '0;
         port_A_we      <= 1'b0;
         port_A_data_in <= '0;
      end else begin
         port_A_we <= (state == S_WB);
         if (accept) dig_q <= digest_addr;
         if (state == S_WB) port_A_data_in <= hash[32 * (4 - int'(cnt[2:0])) +: 32];
      end
   end
`else
   logic unused_digest;
   assign unused_digest  = ^{digest_addr, accept};
   assign port_A_we      = 1'b0;
   assign port_A_data_in = '0;
`endif

endmodule
